arb_grant_dispatcher: RTL and testbench

//  Downstream stage of the 4-way fixed-priority arbiter: consumes its registered
//  2-bit grant, locks the winning source and streams a fixed-length burst

---
 rtl/arb_pkg.sv | 23 ++
 rtl/arb_burst_counter.sv | 39 +++
 rtl/arb_grant_dispatcher.sv | 138 +++++++++++++
 tb/tb_arb_grant_dispatcher.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant dispatcher.
package arb_pkg;

    localparam int N_SRC    = 4;
    localparam int SRC_ID_W = 2;

    typedef logic [SRC_ID_W-1:0] src_id_t;

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_BURST = 2'd1,
        DISP_GAP   = 2'd2
    } disp_state_e;

    // One-hot decode of a source index.
    function automatic logic [N_SRC-1:0] onehot(input src_id_t id);
        logic [N_SRC-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Up-counter with synchronous clear and increment, flagging the final count
// (MAX-1). Used both for beats within a burst and for the post-burst gap.
module arb_burst_counter #(
    parameter int MAX = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment so a new phase always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(MAX - 1));

endmodule

// File: rtl/arb_grant_dispatcher.sv
// Takes the arbiter's registered grant, locks the winning source, streams a
// fixed-length burst from it to the shared sink, then idles for a short gap
// so the arbiter can re-evaluate before the next grant is sampled.
module arb_grant_dispatcher
    import arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  arb_clk,
    input  logic                  arb_rst,
    input  logic [N_SRC-1:0]      arb_req,
    input  logic [SRC_ID_W-1:0]   arb_gnt,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]      src_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [SRC_ID_W-1:0]   out_src,
    output logic                  out_last,
    output logic                  busy,
    output logic [N_SRC-1:0]      done_pulse,
    output logic [N_SRC-1:0]      abort_pulse
);

    disp_state_e      state_q, state_d;
    src_id_t          owner_q, owner_d;
    logic [N_SRC-1:0] done_q, done_d;
    logic [N_SRC-1:0] abort_q, abort_d;

    logic beat_clr, beat_inc, beat_tc;
    logic gap_clr, gap_inc, gap_tc;
    logic owner_req, in_burst, handshake;

    logic [DATA_W-1:0] src_word [N_SRC];

    // Unpack the flat source bus into one word per source.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_word
            assign src_word[gi] = src_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    arb_burst_counter #(.MAX(BURST_LEN)) u_beat_cnt (
        .clk_i   (arb_clk),
        .rst_i   (arb_rst),
        .clear_i (beat_clr),
        .inc_i   (beat_inc),
        .tc_o    (beat_tc)
    );

    arb_burst_counter #(.MAX(GAP_CYCLES)) u_gap_cnt (
        .clk_i   (arb_clk),
        .rst_i   (arb_rst),
        .clear_i (gap_clr),
        .inc_i   (gap_inc),
        .tc_o    (gap_tc)
    );

    assign in_burst  = (state_q == DISP_BURST);
    assign owner_req = arb_req[owner_q];
    assign handshake = out_valid & out_ready;

    // Sink-side outputs: only driven while a burst owns the sink. A dropped
    // owner request pulls out_valid low immediately (abort cycle).
    always_comb begin
        out_valid   = in_burst & owner_req;
        out_data    = out_valid ? src_word[owner_q] : '0;
        out_src     = in_burst ? owner_q : '0;
        out_last    = out_valid & beat_tc;
        src_ready   = onehot(owner_q) & {N_SRC{handshake}};
        busy        = (state_q != DISP_IDLE);
        done_pulse  = done_q;
        abort_pulse = abort_q;
    end

    // Burst ownership FSM: grant sampling, beat/abort accounting, gap timing.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        done_d   = '0;
        abort_d  = '0;
        beat_clr = 1'b0;
        beat_inc = 1'b0;
        gap_clr  = 1'b0;
        gap_inc  = 1'b0;
        case (state_q)
            DISP_IDLE: begin
                beat_clr = 1'b1;
                gap_clr  = 1'b1;
                // A grant whose source has already withdrawn is stale; ignore it.
                if (arb_req[arb_gnt]) begin
                    owner_d = arb_gnt;
                    state_d = DISP_BURST;
                end
            end
            DISP_BURST: begin
                gap_clr = 1'b1;
                if (!owner_req) begin
                    state_d = DISP_GAP;
                    abort_d = onehot(owner_q);
                end else if (handshake) begin
                    beat_inc = 1'b1;
                    if (beat_tc) begin
                        state_d = DISP_GAP;
                        done_d  = onehot(owner_q);
                    end
                end
            end
            DISP_GAP: begin
                gap_inc = 1'b1;
                if (gap_tc) begin
                    state_d = DISP_IDLE;
                end
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    // State, owner and the one-cycle completion/abort pulses.
    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            state_q <= DISP_IDLE;
            owner_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_arb_grant_dispatcher.sv
// Bench for arb_grant_dispatcher: scenario tasks with randomized data,
// backpressure and abort points, expectations derived from burst-level rules.
module tb_arb_grant_dispatcher;

    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [1:0]    gnt;
    logic [4*DW-1:0] sdata;
    logic          ordy;

    logic [3:0]    src_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;
    logic          out_last;
    logic          busy;
    logic [3:0]    done_pulse;
    logic [3:0]    abort_pulse;

    int total = 0;
    int bad   = 0;

    logic [48:0] e;
    wire  [48:0] obs = {busy, out_valid, out_last, out_src, src_ready,
                        done_pulse, abort_pulse, out_data};

    arb_grant_dispatcher #(.DATA_W(DW), .BURST_LEN(BL), .GAP_CYCLES(1)) dut (
        .arb_clk     (clk),
        .arb_rst     (rst),
        .arb_req     (req),
        .arb_gnt     (gnt),
        .src_data    (sdata),
        .src_ready   (src_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (ordy),
        .out_src     (out_src),
        .out_last    (out_last),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .abort_pulse (abort_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] ev(bit b, bit v, bit l, int s, logic [3:0] r,
                                       logic [3:0] d, logic [3:0] a, logic [DW-1:0] dat);
        return {b, v, l, 2'(s), r, d, a, dat};
    endfunction

    function automatic logic [3:0] oh(int s);
        return 4'(1 << s);
    endfunction

    function automatic logic [DW-1:0] word(int s);
        return sdata[s*DW +: DW];
    endfunction

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic new_data;
        sdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; gnt = '0; ordy = 1'b0; new_data();
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_hold obs=%h exp=0", obs); end
        next(); next();
        rst = 1'b0; req = 4'b0100; gnt = 2'd2; ordy = 1'b1;
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_idle obs=%h exp=0", obs); end
        next();
        for (int b = 0; b < 2; b++) begin
            e = ev(1, 1, 0, 2, 4'b0100, 0, 0, word(2));
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL reset_beat%0d obs=%h exp=%h", b, obs, e); end
            if (b == 0) next();
        end
        rst = 1'b1;
        #1; total++;
        if (obs !== '0) begin bad++; $display("FAIL reset_mid obs=%h exp=0", obs); end
        next();
        rst = 1'b0; req = '0;
        for (int k = 0; k < 2; k++) begin
            #2; total++;
            if (obs !== '0) begin bad++; $display("FAIL reset_after%0d obs=%h exp=0", k, obs); end
            next();
        end
    endtask

    task automatic test_single;
        new_data(); req = 4'b0100; gnt = 2'd2; ordy = 1'b1;
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL single_idle obs=%h exp=0", obs); end
        next();
        for (int b = 0; b < BL; b++) begin
            e = ev(1, 1, b == BL-1, 2, 4'b0100, 0, 0, word(2));
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL single_beat%0d obs=%h exp=%h", b, obs, e); end
            next();
        end
        e = ev(1, 0, 0, 0, 0, 4'b0100, 0, 0);
        #2; total++;
        if (obs !== e) begin bad++; $display("FAIL single_gap obs=%h exp=%h", obs, e); end
        next();
        req = '0;
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL single_end obs=%h exp=0", obs); end
        next();
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        int acc, pops;
        pat = 4'b1001; acc = 0; pops = 0;
        new_data(); req = 4'b0001; gnt = 2'd0; ordy = 1'b0;
        #2; next();
        for (int k = 0; k < 40 && acc < BL; k++) begin
            ordy = (k < 4) ? pat[k] : 1'($urandom_range(0, 1));
            e = ev(1, 1, acc == BL-1, 0, ordy ? 4'b0001 : 4'b0000, 0, 0, word(0));
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL bp_cyc%0d obs=%h exp=%h", k, obs, e); end
            if (src_ready[0]) pops++;
            if (ordy) acc++;
            next();
        end
        total++;
        if (pops !== BL) begin bad++; $display("FAIL bp_pops got=%0d exp=%0d", pops, BL); end
        req = '0;
        e = ev(1, 0, 0, 0, 0, 4'b0001, 0, 0);
        #2; total++;
        if (obs !== e) begin bad++; $display("FAIL bp_gap obs=%h exp=%h", obs, e); end
        next();
    endtask

    task automatic test_abort;
        new_data(); req = 4'b0010; gnt = 2'd1; ordy = 1'b1;
        #2; next();
        for (int b = 0; b < 2; b++) begin
            e = ev(1, 1, 0, 1, 4'b0010, 0, 0, word(1));
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL abort_beat%0d obs=%h exp=%h", b, obs, e); end
            next();
        end
        req = '0;
        e = ev(1, 0, 0, 1, 0, 0, 0, 0);
        #2; total++;
        if (obs !== e) begin bad++; $display("FAIL abort_drop obs=%h exp=%h", obs, e); end
        next();
        e = ev(1, 0, 0, 0, 0, 0, 4'b0010, 0);
        #2; total++;
        if (obs !== e) begin bad++; $display("FAIL abort_gap obs=%h exp=%h", obs, e); end
        next();
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL abort_idle obs=%h exp=0", obs); end
        next();
    endtask

    task automatic test_stale;
        new_data(); req = 4'b0001; gnt = 2'd3; ordy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2; total++;
            if (obs !== '0) begin bad++; $display("FAIL stale_cyc%0d obs=%h exp=0", k, obs); end
            next();
        end
        req = '0;
    endtask

    task automatic test_back_to_back;
        int src;
        new_data(); req = 4'b1010; gnt = 2'd1; ordy = 1'b1;
        for (int n = 0; n < 3; n++) begin
            src = (n < 2) ? 1 : 3;
            #2; total++;
            if (obs !== '0) begin bad++; $display("FAIL b2b_idle%0d obs=%h exp=0", n, obs); end
            next();
            for (int b = 0; b < BL; b++) begin
                e = ev(1, 1, b == BL-1, src, oh(src), 0, 0, word(src));
                #2; total++;
                if (obs !== e) begin bad++; $display("FAIL b2b_burst%0d_beat%0d obs=%h exp=%h", n, b, obs, e); end
                next();
            end
            if (n == 1) begin req = 4'b1000; gnt = 2'd3; end
            e = ev(1, 0, 0, 0, 0, oh(src), 0, 0);
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL b2b_gap%0d obs=%h exp=%h", n, obs, e); end
            next();
        end
        req = '0;
        #2; total++;
        if (obs !== '0) begin bad++; $display("FAIL b2b_end obs=%h exp=0", obs); end
        next();
    endtask

    task automatic test_random;
        int src, abort_at, acc;
        bit aborted;
        for (int it = 0; it < 20; it++) begin
            src = $urandom_range(0, 3);
            abort_at = $urandom_range(0, 7);
            new_data();
            req = 4'($urandom_range(0, 15)) | oh(src);
            gnt = 2'(src);
            acc = 0; aborted = 0;
            #2; next();
            for (int k = 0; k < 60; k++) begin
                if (abort_at < BL && acc == abort_at) begin
                    req[src] = 1'b0;
                    e = ev(1, 0, 0, src, 0, 0, 0, 0);
                    #2; total++;
                    if (obs !== e) begin bad++; $display("FAIL rnd%0d_drop obs=%h exp=%h", it, obs, e); end
                    next();
                    aborted = 1;
                    break;
                end
                ordy = 1'($urandom_range(0, 1));
                e = ev(1, 1, acc == BL-1, src, ordy ? oh(src) : 4'b0, 0, 0, word(src));
                #2; total++;
                if (obs !== e) begin bad++; $display("FAIL rnd%0d_cyc%0d obs=%h exp=%h", it, k, obs, e); end
                if (ordy) acc++;
                next();
                if (acc == BL) break;
            end
            if (!aborted && acc != BL) begin
                total++; bad++;
                $display("FAIL rnd%0d_timeout beats=%0d exp=%0d", it, acc, BL);
            end
            req = '0;
            e = ev(1, 0, 0, 0, 0, aborted ? 4'b0 : oh(src), aborted ? oh(src) : 4'b0, 0);
            #2; total++;
            if (obs !== e) begin bad++; $display("FAIL rnd%0d_gap obs=%h exp=%h", it, obs, e); end
            next();
            #2; total++;
            if (obs !== '0) begin bad++; $display("FAIL rnd%0d_idle obs=%h exp=0", it, obs); end
            next();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_abort();
        test_stale();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
